// File: rtl/rate_pkg.sv
// rtl/rate_pkg.sv - shared constants and types for the rate sequencer
package rate_pkg;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int RATE_W  = 11;
  localparam int STEPS_W = 4;
  localparam int CNT_W   = 4;

  localparam logic [1:0] SPEED_HOLD = 2'b00;
  localparam logic [1:0] SPEED_FAST = 2'b01;
  localparam logic [1:0] SPEED_MED  = 2'b10;
  localparam logic [1:0] SPEED_SLOW = 2'b11;

  localparam logic [RATE_W-1:0] RELOAD_HOLD = 11'd0;
  localparam logic [RATE_W-1:0] RELOAD_FAST = 11'd499;
  localparam logic [RATE_W-1:0] RELOAD_MED  = 11'd999;
  localparam logic [RATE_W-1:0] RELOAD_SLOW = 11'd1999;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]         speed;
    logic [STEPS_W-1:0] steps;
  } prog_entry_t;
endpackage

// File: rtl/rate_sequencer_if.sv
// rtl/rate_sequencer_if.sv - control, program-write and status bundle of the rate sequencer
interface rate_sequencer_if;
  import rate_pkg::*;

  logic               start;
  logic               stop;
  logic               write_en;
  logic [ADDR_W-1:0]  write_addr;
  logic [1:0]         write_speed;
  logic [STEPS_W-1:0] write_steps;
  logic               busy;
  logic               done;
  logic               tick;
  logic [ADDR_W-1:0]  entry;
  logic [CNT_W-1:0]   counter_value;

  modport master (
    output start, stop, write_en, write_addr, write_speed, write_steps,
    input  busy, done, tick, entry, counter_value
  );

  modport slave (
    input  start, stop, write_en, write_addr, write_speed, write_steps,
    output busy, done, tick, entry, counter_value
  );
endinterface

// File: rtl/speed_reload_lut.sv
// rtl/speed_reload_lut.sv - speed code to down-counter reload value
module speed_reload_lut
  import rate_pkg::*;
(
  input  logic [1:0]        speed,
  output logic [RATE_W-1:0] reload
);
  always_comb begin
    reload = RELOAD_HOLD;
    case (speed)
      SPEED_HOLD: reload = RELOAD_HOLD;
      SPEED_FAST: reload = RELOAD_FAST;
      SPEED_MED:  reload = RELOAD_MED;
      SPEED_SLOW: reload = RELOAD_SLOW;
      default:    reload = RELOAD_HOLD;
    endcase
  end
endmodule

// File: rtl/rate_sequencer.sv
// rtl/rate_sequencer.sv - runs a 4-entry (speed, steps) program driving the tick divider and display counter
module rate_sequencer
  import rate_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  rate_sequencer_if.slave  bus
);
  logic [1:0]         state;
  logic [RATE_W-1:0]  q;
  logic [STEPS_W-1:0] step_cnt;
  logic [ADDR_W-1:0]  entry_r;
  logic [CNT_W-1:0]   cv;
  prog_entry_t        prog     [DEPTH];
  prog_entry_t        run_prog [DEPTH];
  prog_entry_t        cur;
  logic [RATE_W-1:0]  reload;
  logic               tick_w;

  // The running program is a snapshot taken at Start, so a write in the
  // Start cycle lands in the table without affecting the run it launches.
  assign cur    = run_prog[entry_r];
  assign tick_w = (state == ST_RUN) && (q == '0);

  speed_reload_lut u_lut (
    .speed  (cur.speed),
    .reload (reload)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      q        <= '0;
      step_cnt <= '0;
      entry_r  <= '0;
      cv       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        prog[i]     <= '0;
        run_prog[i] <= '0;
      end
    end else begin
      if (state == ST_IDLE && bus.write_en)
        prog[bus.write_addr] <= '{speed: bus.write_speed, steps: bus.write_steps};

      if (bus.stop && state != ST_IDLE) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start && !bus.stop) begin
              entry_r  <= '0;
              run_prog <= prog;
              state    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (cur.steps == '0) begin
              state <= ST_DONE;
            end else begin
              q        <= reload;
              step_cnt <= cur.steps;
              state    <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (q != '0) begin
              q <= q - 1'b1;
            end else begin
              cv <= cv + 1'b1;
              if (step_cnt != STEPS_W'(1)) begin
                q        <= reload;
                step_cnt <= step_cnt - 1'b1;
              end else if (entry_r == ADDR_W'(DEPTH - 1)) begin
                state <= ST_DONE;
              end else begin
                entry_r <= entry_r + 1'b1;
                state   <= ST_LOAD;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy          = (state == ST_LOAD) || (state == ST_RUN);
  assign bus.done          = (state == ST_DONE);
  assign bus.tick          = tick_w;
  assign bus.entry         = entry_r;
  assign bus.counter_value = cv;
endmodule
